// File: rtl/irq_pkg.sv
// Shared constants and types for the Wishbone interrupt aggregator.
package irq_pkg;

   localparam logic [1:0] IRQ_ADDR_PENDING = 2'd0;
   localparam logic [1:0] IRQ_ADDR_ENABLE  = 2'd1;
   localparam logic [1:0] IRQ_ADDR_MODE    = 2'd2;
   localparam logic [1:0] IRQ_ADDR_ACTIVE  = 2'd3;

   localparam int IRQ_MAX_SRC        = 16;
   localparam int IRQ_ID_W           = 5;
   localparam int IRQ_ACTIVE_VLD_BIT = 31;

   typedef enum logic {
      BUS_IDLE = 1'b0,
      BUS_ACK  = 1'b1
   } bus_state_e;

endpackage

// File: rtl/irq_prio_enc.sv
// Lowest-index-first priority encoder; purely combinational.
module irq_prio_enc
   import irq_pkg::*;
#(
   parameter int N = 8
) (
   input  logic [N-1:0]        req,
   output logic                valid,
   output logic [IRQ_ID_W-1:0] id
);

   always_comb begin
      valid = 1'b0;
      id    = '0;
      // Scan downward so the lowest set index is the last one written.
      for (int i = N - 1; i >= 0; i--) begin
         if (req[i]) begin
            valid = 1'b1;
            id    = IRQ_ID_W'(i);
         end
      end
   end

endmodule

// File: rtl/irq_wb.sv
// Interrupt aggregator: pending/enable/mode registers behind a one-wait-state
// Wishbone slave, edge/level event capture, registered irq and ACTIVE id.
module irq_wb
   import irq_pkg::*;
#(
   parameter int N_SRC = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [1:0]       wb_addr,
   output logic [31:0]      wb_rdata,
   input  logic [31:0]      wb_wdata,
   input  logic             wb_we,
   input  logic             wb_cyc,
   output logic             wb_ack,
   input  logic [N_SRC-1:0] ev_in,
   output logic             irq
);

   bus_state_e state, state_nxt;
   logic capture, commit;

   logic [N_SRC-1:0] pending, enable, mode, prev_ev;
   logic [N_SRC-1:0] pending_nxt, rise, w1c, wdata_src;
   logic [31:0]      rd_mux;

   logic                act_valid;
   logic [IRQ_ID_W-1:0] act_id;

   logic unused_wdata;
   assign unused_wdata = ^wb_wdata[31:N_SRC];

   assign wdata_src = wb_wdata[N_SRC-1:0];
   assign wb_ack    = (state == BUS_ACK);

   // Bus handshake: ack follows every accepted cycle by one clock.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= BUS_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      capture   = 1'b0;
      commit    = 1'b0;
      case (state)
         BUS_IDLE: begin
            if (wb_cyc) begin
               state_nxt = BUS_ACK;
               capture   = ~wb_we;
            end
         end
         BUS_ACK: begin
            state_nxt = BUS_IDLE;
            commit    = wb_cyc & wb_we;
         end
         default: state_nxt = BUS_IDLE;
      endcase
   end

   irq_prio_enc #(.N(N_SRC)) u_prio (
      .req   (pending & enable),
      .valid (act_valid),
      .id    (act_id)
   );

   always_comb begin
      rd_mux = '0;
      case (wb_addr)
         IRQ_ADDR_PENDING: rd_mux = 32'(pending);
         IRQ_ADDR_ENABLE:  rd_mux = 32'(enable);
         IRQ_ADDR_MODE:    rd_mux = 32'(mode);
         IRQ_ADDR_ACTIVE:  rd_mux = {act_valid, 26'b0, act_id};
         default:          rd_mux = '0;
      endcase
   end

   // Event capture: an edge sets and holds, a level simply follows the line.
   always_comb begin
      rise        = ev_in & ~prev_ev;
      w1c         = (commit && wb_addr == IRQ_ADDR_PENDING) ? wdata_src : '0;
      pending_nxt = (mode & (rise | (pending & ~w1c))) | (~mode & ev_in);
      if (commit && wb_addr == IRQ_ADDR_MODE)
         pending_nxt = pending_nxt & ~(wdata_src ^ mode);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pending  <= '0;
         enable   <= '0;
         mode     <= '0;
         prev_ev  <= '0;
         irq      <= 1'b0;
         wb_rdata <= '0;
      end else begin
         pending  <= pending_nxt;
         prev_ev  <= ev_in;
         irq      <= |(pending & enable);
         wb_rdata <= capture ? rd_mux : '0;
         if (commit && wb_addr == IRQ_ADDR_ENABLE) enable <= wdata_src;
         if (commit && wb_addr == IRQ_ADDR_MODE)   mode   <= wdata_src;
      end
   end

endmodule

// File: tb/tb_irq_wb.sv
// Self-checking bench for irq_wb: directed scenarios plus randomized traffic
// against a cycle-level behavioural model of the register rules.
module tb_irq_wb;

   localparam int N = 8;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [1:0]    wb_addr;
   logic [31:0]   wb_rdata;
   logic [31:0]   wb_wdata;
   logic          wb_we;
   logic          wb_cyc;
   logic          wb_ack;
   logic [N-1:0]  ev_in;
   logic          irq;

   int n_checks = 0;
   int n_errors = 0;

   logic [N-1:0] m_pend, m_en, m_mode, m_prev;
   logic         m_irq, m_ack;
   logic [31:0]  m_rdata;
   logic [31:0]  rd;

   irq_wb #(.N_SRC(N)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .wb_addr  (wb_addr),
      .wb_rdata (wb_rdata),
      .wb_wdata (wb_wdata),
      .wb_we    (wb_we),
      .wb_cyc   (wb_cyc),
      .wb_ack   (wb_ack),
      .ev_in    (ev_in),
      .irq      (irq)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic m_reset();
      m_pend = '0; m_en = '0; m_mode = '0; m_prev = '0;
      m_irq = 1'b0; m_ack = 1'b0; m_rdata = '0;
   endtask

   function automatic logic [31:0] m_read(input logic [1:0] a);
      logic [31:0] r;
      r = '0;
      case (a)
         2'd0: r = 32'(m_pend);
         2'd1: r = 32'(m_en);
         2'd2: r = 32'(m_mode);
         default: begin
            for (int i = N - 1; i >= 0; i--)
               if (m_pend[i] && m_en[i]) r = 32'h8000_0000 | 32'(i);
         end
      endcase
      return r;
   endfunction

   // Advance one clock: model computes the next state from current inputs,
   // then ack, rdata and irq are compared just after the edge.
   task automatic step();
      logic [N-1:0] np, ne, nm;
      logic         commit, w1c_bit, nirq, nack;
      logic [31:0]  nrd;
      commit = m_ack && wb_cyc && wb_we;
      nrd    = (wb_cyc && !m_ack && !wb_we) ? m_read(wb_addr) : 32'd0;
      nack   = wb_cyc && !m_ack;
      nirq   = (m_pend & m_en) != '0;
      ne     = (commit && wb_addr == 2'd1) ? wb_wdata[N-1:0] : m_en;
      nm     = (commit && wb_addr == 2'd2) ? wb_wdata[N-1:0] : m_mode;
      for (int i = 0; i < N; i++) begin
         w1c_bit = commit && wb_addr == 2'd0 && wb_wdata[i];
         if (m_mode[i]) np[i] = (ev_in[i] && !m_prev[i]) || (m_pend[i] && !w1c_bit);
         else           np[i] = ev_in[i];
         if (nm[i] != m_mode[i]) np[i] = 1'b0;
      end
      @(posedge clk);
      m_prev = ev_in; m_pend = np; m_en = ne; m_mode = nm;
      m_irq = nirq; m_ack = nack; m_rdata = nrd;
      #1;
      chk("ack", {31'b0, wb_ack}, {31'b0, m_ack});
      chk("rdata", wb_rdata, m_rdata);
      chk("irq", {31'b0, irq}, {31'b0, m_irq});
   endtask

   task automatic wb_write(input logic [1:0] a, input logic [31:0] d);
      wb_addr = a; wb_wdata = d; wb_we = 1'b1; wb_cyc = 1'b1;
      step();
      step();
      wb_cyc = 1'b0; wb_we = 1'b0;
   endtask

   task automatic wb_read(input logic [1:0] a, output logic [31:0] d);
      wb_addr = a; wb_we = 1'b0; wb_cyc = 1'b1;
      step();
      d = wb_rdata;
      step();
      wb_cyc = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0; wb_addr = '0; wb_wdata = '0; wb_we = 1'b0; wb_cyc = 1'b0; ev_in = '0;
      m_reset();
      #12;
      chk("rst_ack", {31'b0, wb_ack}, 32'd0);
      chk("rst_rdata", wb_rdata, 32'd0);
      chk("rst_irq", {31'b0, irq}, 32'd0);
      rst_n = 1'b1;

      // Edge path
      wb_write(2'd2, 32'h01);
      wb_write(2'd1, 32'h01);
      ev_in = 8'h01;
      step();
      ev_in = 8'h00;
      chk("edge_irq_k", {31'b0, irq}, 32'd0);
      step();
      chk("edge_irq_k1", {31'b0, irq}, 32'd1);
      wb_read(2'd0, rd); chk("edge_pend", rd, 32'h01);
      wb_read(2'd3, rd); chk("edge_active", rd, 32'h8000_0000);
      wb_write(2'd0, 32'h01);
      chk("edge_w1c_commit", {31'b0, irq}, 32'd1);
      step();
      chk("edge_w1c_irq", {31'b0, irq}, 32'd0);

      // Priority
      wb_write(2'd2, 32'hFF);
      wb_write(2'd1, 32'hFF);
      ev_in = 8'h24;
      step();
      ev_in = 8'h00;
      step();
      wb_read(2'd3, rd); chk("prio_first", rd, 32'h8000_0002);
      wb_write(2'd0, 32'h04);
      wb_read(2'd3, rd); chk("prio_second", rd, 32'h8000_0005);
      wb_write(2'd0, 32'h20);
      step();
      chk("prio_clear_irq", {31'b0, irq}, 32'd0);

      // Set/clear collision on edge bit 3
      ev_in = 8'h08; step(); ev_in = 8'h00; step();
      wb_read(2'd0, rd); chk("coll_pre", rd, 32'h08);
      wb_addr = 2'd0; wb_wdata = 32'h08; wb_we = 1'b1; wb_cyc = 1'b1;
      step();
      ev_in = 8'h08;
      step();
      wb_cyc = 1'b0; wb_we = 1'b0; ev_in = 8'h00;
      wb_read(2'd0, rd); chk("coll_pend", rd, 32'h08);
      chk("coll_irq", {31'b0, irq}, 32'd1);
      wb_write(2'd0, 32'h08);
      step(); step();

      // Level and mask
      wb_write(2'd2, 32'h00);
      wb_write(2'd1, 32'h00);
      ev_in = 8'h02;
      step(); step();
      wb_read(2'd0, rd); chk("lvl_pend", rd, 32'h02);
      chk("lvl_masked_irq", {31'b0, irq}, 32'd0);
      wb_write(2'd1, 32'h02);
      chk("lvl_en_commit", {31'b0, irq}, 32'd0);
      step();
      chk("lvl_en_irq", {31'b0, irq}, 32'd1);
      ev_in = 8'h00;
      step();
      chk("lvl_drop_k", {31'b0, irq}, 32'd1);
      step();
      chk("lvl_drop_k1", {31'b0, irq}, 32'd0);
      wb_read(2'd0, rd); chk("lvl_pend_clr", rd, 32'h00);

      // Back-to-back reads with cyc held
      wb_write(2'd1, 32'hA5);
      wb_write(2'd2, 32'h5A);
      ev_in = 8'h81;
      step(); step();
      wb_we = 1'b0; wb_cyc = 1'b1;
      for (int a = 0; a < 4; a++) begin
         wb_addr = 2'(a);
         step();
         chk("b2b_ack_hi", {31'b0, wb_ack}, 32'd1);
         chk("b2b_rdata_nz", {31'b0, wb_rdata != 32'd0}, 32'd1);
         step();
         chk("b2b_ack_lo", {31'b0, wb_ack}, 32'd0);
         chk("b2b_rdata_zero", wb_rdata, 32'd0);
      end
      wb_cyc = 1'b0;

      // Reset asserted in the middle of a read
      wb_addr = 2'd1; wb_cyc = 1'b1;
      step();
      #2 rst_n = 1'b0;
      #1;
      chk("mid_rst_ack", {31'b0, wb_ack}, 32'd0);
      chk("mid_rst_rdata", wb_rdata, 32'd0);
      chk("mid_rst_irq", {31'b0, irq}, 32'd0);
      wb_cyc = 1'b0; ev_in = '0;
      m_reset();
      @(posedge clk);
      @(negedge clk) rst_n = 1'b1;
      wb_read(2'd0, rd); chk("post_rst_pend", rd, 32'h0);
      wb_read(2'd1, rd); chk("post_rst_en", rd, 32'h0);
      wb_read(2'd2, rd); chk("post_rst_mode", rd, 32'h0);

      // Randomized traffic against the model
      for (int t = 0; t < 600; t++) begin
         int idle;
         idle = $urandom_range(0, 2);
         for (int c = 0; c < idle; c++) begin
            ev_in = N'($urandom & $urandom);
            step();
         end
         wb_addr = 2'($urandom_range(0, 3));
         wb_we = 1'($urandom_range(0, 1));
         wb_wdata = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 255));
         wb_cyc = 1'b1;
         ev_in = N'($urandom & $urandom);
         step();
         ev_in = N'($urandom & $urandom);
         step();
         wb_cyc = 1'b0; wb_we = 1'b0;
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
